uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer and launch sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer (CPU/logic) at any rate up to one per clock and stores them in a circular FIFO.
- Drains the FIFO one byte per frame: pulses tx_dv with tx_byte, then tracks the transmitter's tx_active/tx_done handshake before releasing the next byte.
- Lets producers burst messages without polling the serialiser.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
- wr_en  in  1  producer write strobe; one byte per cycle when high.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds DEPTH bytes; writes are dropped.
- empty  out  1  FIFO holds 0 bytes.
- busy  out  1  high when FIFO is non-empty or the FSM is not in S_IDLE; low means everything has been sent.
- tx_dv  out  1  one-cycle launch pulse to the transmitter.
- tx_byte  out  8  byte to the transmitter; held stable from the tx_dv pulse until the next launch.
- tx_active  in  1  transmitter busy, from the transmitter.
- tx_done  in  1  frame complete; the transmitter holds it high for 2 cycles.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Pointers and count = 0; FSM = S_IDLE.
  - tx_dv=0, tx_byte=8'h00, full=0, empty=1, busy=0.
  - Storage contents are don't-care.
  - Reset mid-frame discards queued bytes and drops tracking of the frame in flight; the transmitter is reset from the same domain.
- Storage:
  - DEPTH x 8 array; wr_ptr and rd_ptr are AW bits and wrap naturally at DEPTH.
  - count is AW+1 bits.
  - full = (count==DEPTH) and empty = (count==0), both derived from the registered count.
- Write rules:
  - If wr_en && !full: mem[wr_ptr]<=wr_data, wr_ptr+1.
  - If wr_en && full: byte is dropped, no state change. This holds even if a pop occurs in the same cycle; full is evaluated on the pre-edge count.
- Pop and write in the same cycle: count unchanged, both pointers advance.
- FSM states:
  - S_IDLE:
    - If !empty && !tx_active && !tx_done: tx_byte<=mem[rd_ptr], rd_ptr+1, tx_dv<=1, go to S_START.
    - Otherwise stay in S_IDLE.
  - S_START: tx_dv<=0. If tx_active==1, go to S_WAIT_DONE; else stay.
  - S_WAIT_DONE: wait for tx_done==1, then go to S_IDLE.
- Spacing between frames:
  - The S_IDLE guard on tx_done absorbs the transmitter's 2-cycle tx_done.
  - The next tx_dv therefore rises at least 2 cycles after tx_done first goes high.
- tx_dv is registered and is high for exactly one cycle per popped byte; it never asserts while tx_active=1.
- Latency: wr_en in cycle 0 with an empty FIFO and idle transmitter -> tx_dv high in cycle 2 (count update, then launch).
- Bytes are sent strictly in write order. No byte is lost unless it was written while full.

Optional Feature:
- Macro: UART_TX_FIFO_STATUS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): sticky; set on any wr_en while full; cleared only by reset.
  - level (AW+1 bits): equal to count.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single byte: reset, write 8'hA5 with the real transmitter (FREQUENCY=10_000_000, BAUD_RATE=9600) -> tx_dv pulses 2 cycles after the write with tx_byte=8'hA5; serial line shows start bit, 1,0,1,0,0,1,0,1 LSB-first, stop bit; busy falls after tx_done.
- Burst: write 8'h01..8'h05 on consecutive cycles -> five frames in order 01..05; exactly five tx_dv pulses; each pulse occurs only while tx_active=0 and tx_done=0.
- Full/overflow, DEPTH=4, transmitter stalled (tx_active held 1): write 6 bytes -> full=1 after the 4th write; bytes 5-6 are dropped; overflow=1 with the macro enabled; after release, only bytes 1-4 are sent.
- Simultaneous write and pop at count=1 -> count stays 1, pointers wrap correctly past DEPTH-1, order preserved across the wrap (write 2*DEPTH+3 bytes total, all received in order).
- Reset mid-frame: drive reset_n=0 for 1 cycle while 3 bytes are queued -> empty=1, tx_dv=0, busy=0 next cycle; a subsequent write of 8'h3C is sent normally.
- Handshake corner: model drives tx_done high for 2 cycles, with tx_active falling together with tx_done -> exactly one launch per frame; no double pop.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding a UART transmitter.
// Optional status outputs (overflow, level) under UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [7:0]   wr_data,
    output logic         full,
    output logic         empty,
    output logic         busy,
    output logic         tx_dv,
    output logic [7:0]   tx_byte,
    input  logic         tx_active,
    input  logic         tx_done
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    output logic         overflow,
    output logic [AW:0]  level
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign busy  = !empty || (state != S_IDLE);

    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
    assign push = wr_en && !full;
    assign pop  = (state == S_IDLE) && !empty && !tx_active && !tx_done;

    // Byte storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch sequencer: pulse tx_dv, then follow tx_active/tx_done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    tx_dv <= 1'b0;
                    if (pop) begin
                        tx_byte <= mem[rd_ptr];
                        tx_dv   <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    tx_dv <= 1'b0;
                    if (tx_active) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    tx_dv <= 1'b0;
                    if (tx_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_dv <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_STATUS_EN
    assign level = count;

    // Sticky flag for any write attempted while full.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with a behavioural transmitter model.
// Scoreboard queue of written bytes compared against launched bytes.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int FRAME = 10;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic        busy;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
`ifdef UART_TX_FIFO_STATUS_EN
    logic        overflow;
    logic [AW:0] level;
`endif

    int checks;
    int failures;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         dv_pulses;
    int         viol;

    logic       stall;
    logic       act_r;
    logic       done_r;
    int         cnt;
    int         dleft;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done)
`ifdef UART_TX_FIFO_STATUS_EN
        ,
        .overflow  (overflow),
        .level     (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_active = act_r | stall;
    assign tx_done   = done_r;

    // Transmitter model: FRAME cycles active, then tx_done for 2 cycles
    // with tx_active dropping as tx_done rises.
    always @(posedge clk) begin
        if (!reset_n) begin
            act_r  <= 1'b0;
            done_r <= 1'b0;
            cnt    <= 0;
            dleft  <= 0;
        end else if (tx_dv) begin
            dv_pulses = dv_pulses + 1;
            if (tx_active || tx_done) viol = viol + 1;
            rx_q.push_back(tx_byte);
            act_r <= 1'b1;
            cnt   <= FRAME;
        end else if (act_r) begin
            if (cnt == 0) begin
                act_r  <= 1'b0;
                done_r <= 1'b1;
                dleft  <= 1;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (done_r) begin
            if (dleft == 0) done_r <= 1'b0;
            else dleft <= dleft - 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        dv_pulses = 0;
        viol = 0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || tx_active || tx_done) && n < 3000) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s drain timeout busy=%b", name, busy);
        end
    endtask

    task automatic compare_rx(input string name);
        checks++;
        if (rx_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s rx_count got=%0d exp=%0d", name,
                     rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s byte%0d got=%h exp=%h", name, i,
                         rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL %s dv_while_busy got=%0d exp=0", name, viol);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({empty, full, busy, tx_dv} !== 4'b1000) begin
            failures++;
            $display("FAIL reset flags got=%b exp=1000",
                     {empty, full, busy, tx_dv});
        end
        checks++;
        if (tx_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset tx_byte got=%h exp=00", tx_byte);
        end
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        checks++;
        if (tx_dv !== 1'b0) begin
            failures++;
            $display("FAIL single dv_cycle1 got=%b exp=0", tx_dv);
        end
        checks++;
        if (busy !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL single busy/empty got=%b%b exp=10", busy, empty);
        end
        cyc();
        checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin
            failures++;
            $display("FAIL single launch got=%b/%h exp=1/a5", tx_dv, tx_byte);
        end
        cyc();
        checks++;
        if (tx_dv !== 1'b0 || tx_byte !== 8'hA5) begin
            failures++;
            $display("FAIL single hold got=%b/%h exp=0/a5", tx_dv, tx_byte);
        end
        drain("single");
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL single idle got=%b%b exp=01", busy, empty);
        end
        compare_rx("single");
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            write_byte(8'(i));
        end
        drain("burst");
        compare_rx("burst");
        checks++;
        if (dv_pulses !== 5) begin
            failures++;
            $display("FAIL burst pulses got=%0d exp=5", dv_pulses);
        end
    endtask

    task automatic test_full();
        do_reset();
        stall = 1'b1;
        cyc();
        for (int i = 1; i <= 6; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(8'h10 + i));
            write_byte(8'(8'h10 + i));
            if (i == DEPTH) begin
                checks++;
                if (full !== 1'b1) begin
                    failures++;
                    $display("FAIL full after%0d got=%b exp=1", i, full);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || dv_pulses !== 0) begin
            failures++;
            $display("FAIL full stalled got=%b/%0d exp=1/0", full, dv_pulses);
        end
`ifdef UART_TX_FIFO_STATUS_EN
        checks++;
        if (overflow !== 1'b1 || level !== (AW+1)'(DEPTH)) begin
            failures++;
            $display("FAIL full status got=%b/%0d exp=1/%0d",
                     overflow, level, DEPTH);
        end
`endif
        stall = 1'b0;
        drain("full");
        compare_rx("full");
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        stall = 1'b1;
        exp_q.push_back(8'h40);
        write_byte(8'h40);
        stall   = 1'b0;
        exp_q.push_back(8'h41);
        write_byte(8'h41);
        checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'h40) begin
            failures++;
            $display("FAIL wrap pop got=%b/%h exp=1/40", tx_dv, tx_byte);
        end
        checks++;
        if (empty !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL wrap count1 empty/full got=%b%b exp=00",
                     empty, full);
        end
`ifdef UART_TX_FIFO_STATUS_EN
        checks++;
        if (level !== (AW+1)'(1)) begin
            failures++;
            $display("FAIL wrap level got=%0d exp=1", level);
        end
`endif
        for (int i = 2; i < 2 * DEPTH + 3; i++) begin
            n = 0;
            while (full && n < 500) begin
                cyc();
                n++;
            end
            exp_q.push_back(8'(8'h40 + i));
            write_byte(8'(8'h40 + i));
        end
        drain("wrap");
        compare_rx("wrap");
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall = 1'b1;
        write_byte(8'h71);
        write_byte(8'h72);
        write_byte(8'h73);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        stall   = 1'b0;
        checks++;
        if ({empty, tx_dv, busy} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid flags got=%b exp=100", {empty, tx_dv, busy});
        end
        rx_q.delete();
        dv_pulses = 0;
        exp_q.push_back(8'h3C);
        write_byte(8'h3C);
        drain("rstmid");
        compare_rx("rstmid");
        checks++;
        if (dv_pulses !== 1) begin
            failures++;
            $display("FAIL rstmid pulses got=%0d exp=1", dv_pulses);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        dv_pulses = 0;
        viol      = 0;
        stall     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        reset_n   = 1'b0;
        #1;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
